// File: rtl/track_mode_decider.sv
// Turns three raw IR line sensors into the registered drive mode for the motor
// block. The sensors are resynchronised and debounced before any decision. A
// tracking FSM then follows the line, searches toward the side where the line
// was last seen, and gives up with a stop after a search timeout.
module track_mode_decider #(
    parameter int DEBOUNCE     = 1000,
    parameter int LOST_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    output logic [2:0] mode,
    output logic       lost
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int LTW = $clog2(LOST_TIMEOUT + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE);
    localparam logic [LTW-1:0] LT_MAX  = LTW'(LOST_TIMEOUT);

    localparam logic [2:0] MODE_TURN_LEFT   = 3'b000;
    localparam logic [2:0] MODE_TURN_RIGHT  = 3'b001;
    localparam logic [2:0] MODE_STRAIGHT    = 3'b010;
    localparam logic [2:0] MODE_STOP        = 3'b011;
    localparam logic [2:0] MODE_SHARP_LEFT  = 3'b100;
    localparam logic [2:0] MODE_SHARP_RIGHT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_SEARCH,
        ST_HALT
    } state_t;

    logic [2:0]     syncMeta_q;
    logic [2:0]     syncPat_q;
    logic [2:0]     prevPat_q;
    logic [DBW-1:0] dbCount_q;
    logic [2:0]     stablePat_q;

    state_t         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic           lastLeft_q, lastLeft_d;
    logic [LTW-1:0] lostCount_q, lostCount_d;

    logic           patMapped;
    logic           patLost;
    logic [2:0]     patMode;

    // Two-flop resync, then accept a pattern once it has held for DEBOUNCE cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            syncMeta_q  <= '0;
            syncPat_q   <= '0;
            prevPat_q   <= '0;
            dbCount_q   <= '0;
            stablePat_q <= '0;
        end else begin
            syncMeta_q <= {left_track, mid_track, right_track};
            syncPat_q  <= syncMeta_q;
            prevPat_q  <= syncPat_q;
            if (syncPat_q != prevPat_q) begin
                dbCount_q <= '0;
            end else begin
                if (dbCount_q != DB_MAX) begin
                    dbCount_q <= dbCount_q + 1'b1;
                end
                if (dbCount_q >= DB_LAST) begin
                    stablePat_q <= syncPat_q;
                end
            end
        end
    end

    // Map the debounced pattern to a drive mode; 000 (lost) and 101 (no info) are unmapped.
    always_comb begin
        patMapped = 1'b1;
        patMode   = MODE_STOP;
        patLost   = (stablePat_q == 3'b000);
        unique case (stablePat_q)
            3'b010, 3'b111: patMode = MODE_STRAIGHT;
            3'b110:         patMode = MODE_TURN_LEFT;
            3'b011:         patMode = MODE_TURN_RIGHT;
            3'b100:         patMode = MODE_SHARP_LEFT;
            3'b001:         patMode = MODE_SHARP_RIGHT;
            default:        patMapped = 1'b0;
        endcase
    end

    // Next-state, next-mode and last-seen-side decision; dropping run overrides everything.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lastLeft_d  = lastLeft_q;
        lostCount_d = lostCount_q;
        if (!run) begin
            state_d     = ST_IDLE;
            mode_d      = MODE_STOP;
            lostCount_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_TRACK: begin
                    if (patMapped) begin
                        state_d = ST_TRACK;
                        mode_d  = patMode;
                        if (state_q == ST_TRACK) begin
                            if ((patMode == MODE_TURN_LEFT) || (patMode == MODE_SHARP_LEFT)) begin
                                lastLeft_d = 1'b1;
                            end else if ((patMode == MODE_TURN_RIGHT) || (patMode == MODE_SHARP_RIGHT)) begin
                                lastLeft_d = 1'b0;
                            end
                        end
                    end else if (patLost) begin
                        state_d     = ST_SEARCH;
                        mode_d      = lastLeft_q ? MODE_SHARP_LEFT : MODE_SHARP_RIGHT;
                        lostCount_d = '0;
                    end else if (state_q == ST_IDLE) begin
                        state_d = ST_TRACK;
                        mode_d  = MODE_STRAIGHT;
                    end
                end
                ST_SEARCH: begin
                    if (patMapped) begin
                        state_d     = ST_TRACK;
                        mode_d      = patMode;
                        lostCount_d = '0;
                    end else begin
                        lostCount_d = lostCount_q + 1'b1;
                        if (lostCount_d == LT_MAX) begin
                            state_d = ST_HALT;
                            mode_d  = MODE_STOP;
                        end
                    end
                end
                ST_HALT: begin
                    if (patMapped) begin
                        state_d = ST_TRACK;
                        mode_d  = patMode;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mode_d  = MODE_STOP;
                end
            endcase
        end
    end

    // FSM registers; reset parks the car stopped with the left side as the default search direction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_STOP;
            lastLeft_q  <= 1'b1;
            lostCount_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lastLeft_q  <= lastLeft_d;
            lostCount_q <= lostCount_d;
        end
    end

    assign mode = mode_q;
    assign lost = (state_q == ST_SEARCH) || (state_q == ST_HALT);

endmodule

// File: tb/tb_track_mode_decider.sv
// Bench for track_mode_decider with short debounce/timeout values. Directed
// scenarios check fixed expected modes at key edges, and every cycle is also
// compared against a behavioural model of the sensor-to-mode rules.
module tb_track_mode_decider;

    localparam int D  = 4;
    localparam int LT = 16;

    localparam logic [2:0] TL   = 3'b000;
    localparam logic [2:0] TR   = 3'b001;
    localparam logic [2:0] GS   = 3'b010;
    localparam logic [2:0] STOP = 3'b011;
    localparam logic [2:0] SL   = 3'b100;
    localparam logic [2:0] SR   = 3'b101;

    localparam int S_IDLE   = 0;
    localparam int S_TRACK  = 1;
    localparam int S_SEARCH = 2;
    localparam int S_HALT   = 3;

    logic       clk;
    logic       rst;
    logic       run;
    logic [2:0] raw;
    logic [2:0] mode;
    logic       lost;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw samples per edge, debounced pattern and tracker state.
    logic [2:0] hist[$];
    int         barrier;
    logic [2:0] mStable;
    int         mState;
    logic [2:0] mMode;
    bit         mLeft;
    int         mCnt;

    track_mode_decider #(
        .DEBOUNCE    (D),
        .LOST_TIMEOUT(LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .left_track (raw[2]),
        .mid_track  (raw[1]),
        .right_track(raw[0]),
        .mode       (mode),
        .lost       (lost)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the mode for a mapped pattern, -1 for line lost, -2 for no information.
    function automatic int mapPat(input logic [2:0] p);
        case (p)
            3'b010, 3'b111: return int'(GS);
            3'b110:         return int'(TL);
            3'b011:         return int'(TR);
            3'b100:         return int'(SL);
            3'b001:         return int'(SR);
            3'b000:         return -1;
            default:        return -2;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs sampled at that edge.
    task automatic modelStep(input bit rstS, input bit runS, input logic [2:0] rawS);
        int  k;
        int  m;
        bit  same;
        k = hist.size();
        if (!rstS) begin
            hist.push_back(3'b000);
            hist[k-1] = 3'b000;
            hist[k-2] = 3'b000;
            barrier = k - 2;
            mStable = 3'b000;
            mState  = S_IDLE;
            mMode   = STOP;
            mLeft   = 1'b1;
            mCnt    = 0;
        end else begin
            m = mapPat(mStable);
            if (!runS) begin
                mState = S_IDLE;
                mMode  = STOP;
                mCnt   = 0;
            end else if (mState == S_IDLE || mState == S_TRACK) begin
                if (m >= 0) begin
                    if (mState == S_TRACK) begin
                        if (m == int'(TL) || m == int'(SL)) mLeft = 1'b1;
                        if (m == int'(TR) || m == int'(SR)) mLeft = 1'b0;
                    end
                    mState = S_TRACK;
                    mMode  = 3'(m);
                end else if (m == -1) begin
                    mState = S_SEARCH;
                    mMode  = mLeft ? SL : SR;
                    mCnt   = 0;
                end else if (mState == S_IDLE) begin
                    mState = S_TRACK;
                    mMode  = GS;
                end
            end else if (mState == S_SEARCH) begin
                if (m >= 0) begin
                    mState = S_TRACK;
                    mMode  = 3'(m);
                    mCnt   = 0;
                end else begin
                    mCnt = mCnt + 1;
                    if (mCnt == LT) begin
                        mState = S_HALT;
                        mMode  = STOP;
                    end
                end
            end else begin
                if (m >= 0) begin
                    mState = S_TRACK;
                    mMode  = 3'(m);
                end
            end
            hist.push_back(rawS);
            // A raw pattern seen on D+1 consecutive edges becomes stable two edges later.
            if (k - D - 2 >= barrier) begin
                same = 1'b1;
                for (int j = k - D - 2; j <= k - 2; j++) begin
                    if (hist[j] !== hist[k-2]) same = 1'b0;
                end
                if (same) mStable = hist[k-2];
            end
        end
    endtask

    // Compares DUT outputs with the model.
    task automatic checkOutput();
        checks++;
        assert (mode === mMode) else begin
            errors++;
            $error("[TB] FAIL model_mode: observed %b expected %b at %0t", mode, mMode, $time);
        end
        checks++;
        assert (lost === (mState == S_SEARCH || mState == S_HALT)) else begin
            errors++;
            $error("[TB] FAIL model_lost: observed %b expected %b at %0t", lost,
                   (mState == S_SEARCH || mState == S_HALT), $time);
        end
    endtask

    // Compares DUT outputs with fixed values for a directed scenario point.
    task automatic expectOut(input string tag, input logic [2:0] eMode, input logic eLost);
        checks++;
        assert (mode === eMode) else begin
            errors++;
            $error("[TB] FAIL %s mode: observed %b expected %b", tag, mode, eMode);
        end
        checks++;
        assert (lost === eLost) else begin
            errors++;
            $error("[TB] FAIL %s lost: observed %b expected %b", tag, lost, eLost);
        end
    endtask

    // Holds the given inputs for n edges, checking against the model after each one.
    task automatic applyStimulus(input bit r, input bit rn, input logic [2:0] p, input int n);
        rst = r;
        run = rn;
        raw = p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep(rst, run, raw);
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        int hold;
        hist.push_back(3'b000);
        hist.push_back(3'b000);
        barrier = 0;
        mStable = 3'b000;
        mState  = S_IDLE;
        mMode   = STOP;
        mLeft   = 1'b1;
        mCnt    = 0;

        $display("[TB] reset behaviour");
        applyStimulus(1'b0, 1'b1, 3'b010, 1);
        expectOut("reset_1", STOP, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b010, 1);
        expectOut("reset_2", STOP, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b010, 1);
        expectOut("reset_3", STOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b010, 7);
        expectOut("post_reset_edge6", SL, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b010, 1);
        expectOut("post_reset_edge7", GS, 1'b0);

        $display("[TB] glitch rejection");
        applyStimulus(1'b1, 1'b1, 3'b010, 5);
        expectOut("steady_straight", GS, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 3);
        applyStimulus(1'b1, 1'b1, 3'b010, 12);
        expectOut("glitch_rejected", GS, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 7);
        expectOut("turn_left_edge6", GS, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 1);
        expectOut("turn_left_edge7", TL, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 2);

        $display("[TB] lost search and timeout");
        applyStimulus(1'b1, 1'b1, 3'b011, 12);
        expectOut("turn_right", TR, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 7);
        expectOut("before_search", TR, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 1);
        expectOut("search_right", SR, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b000, 15);
        expectOut("search_edge15", SR, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b000, 1);
        expectOut("halt_edge16", STOP, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b100, 7);
        expectOut("halt_held", STOP, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b100, 1);
        expectOut("halt_exit", SL, 1'b0);

        $display("[TB] reacquire during search");
        applyStimulus(1'b1, 1'b1, 3'b100, 2);
        applyStimulus(1'b1, 1'b1, 3'b000, 7);
        expectOut("still_tracking", SL, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 1);
        expectOut("search_left", SL, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b010, 7);
        expectOut("search_cycle7", SL, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b010, 1);
        expectOut("reacquire_cycle8", GS, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b010, 20);
        expectOut("no_halt", GS, 1'b0);

        $display("[TB] no-information hold");
        applyStimulus(1'b1, 1'b1, 3'b011, 8);
        expectOut("track_right", TR, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b101, 12);
        expectOut("noinfo_hold", TR, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 8);
        expectOut("search_from_noinfo", SR, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b101, 15);
        expectOut("noinfo_search15", SR, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b101, 1);
        expectOut("noinfo_timeout", STOP, 1'b1);

        $display("[TB] run control");
        applyStimulus(1'b1, 1'b1, 3'b010, 7);
        expectOut("halt_before_track", STOP, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b010, 1);
        expectOut("track_again", GS, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b010, 1);
        expectOut("run_drop", STOP, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b000, 10);
        expectOut("idle_hold", STOP, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 1);
        expectOut("run_into_search", SR, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 70; n++) begin
            hold = int'($urandom_range(1, 12));
            applyStimulus(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) != 0),
                          3'($urandom_range(0, 7)), hold);
        end

        applyStimulus(1'b0, 1'b1, 3'b111, 1);
        expectOut("final_reset", STOP, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
